// File: rtl/cnt_pkg.sv
// Shared types for the cascadable counter: command modes, FSM states and
// the default slice width used by the carry chain.
package cnt_pkg;

  localparam int SLICE_DEFAULT = 4;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    COUNT = 2'b01,
    LOAD  = 2'b10,
    CLEAR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/cnt_slice.sv
// One SLICE-bit stage of the counter: synchronous clear/load/increment with
// a ripple carry so that a stage only steps when every lower stage is all-ones.
module cnt_slice
  import cnt_pkg::*;
#(
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic             clear,
  input  logic             cin,
  input  logic [SLICE-1:0] load_data,
  output logic [SLICE-1:0] count,
  output logic             cout
);

  logic [SLICE-1:0] q;

  // NOTE: state registers use non-blocking assignments so every slice samples
  // the same pre-edge carry chain; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (inc && cin) begin
      q <= q + SLICE'(1);
    end
  end

  assign count = q;
  assign cout  = cin && (&q);

endmodule

// File: rtl/cnt16_cascade.sv
// Cascadable up-counter built from ripple-carry slices, with a small
// IDLE/RUN/DONE control FSM, terminal-count pulse and optional one-shot stop.
module cnt16_cascade
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SLICE   = SLICE_DEFAULT,
  parameter int ONESHOT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             cnt_en,
  input  logic             cin,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             cout,
  output logic [1:0]       state_o
);

  localparam int NSLICE = WIDTH / SLICE;

  state_e            state_q, state_d;
  mode_e             mode_c;
  logic [NSLICE:0]   carry;
  logic              all_ones;
  logic              count_cmd, load_cmd, clear_cmd;
  logic              inc_fire, wrap, slice_inc;
  logic              ready_q, tc_q;

  assign mode_c    = mode_e'(mode);
  assign count_cmd = (mode_c == COUNT) && cnt_en && cin;
  assign load_cmd  = (mode_c == LOAD) && load_valid && ready_q;
  assign clear_cmd = (mode_c == CLEAR);

  // DONE freezes the count; only load or clear leave it.
  assign inc_fire  = count_cmd && (state_q != DONE);
  assign all_ones  = carry[NSLICE];
  assign wrap      = inc_fire && all_ones;
  assign slice_inc = inc_fire && !((ONESHOT != 0) && all_ones);

  assign carry[0] = 1'b1;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    cnt_slice #(.SLICE(SLICE)) u_slice (
      .clk       (clk),
      .rst       (rst),
      .inc       (slice_inc),
      .load      (load_cmd),
      .clear     (clear_cmd),
      .cin       (carry[k]),
      .load_data (load_data[k*SLICE +: SLICE]),
      .count     (count[k*SLICE +: SLICE]),
      .cout      (carry[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      tc_q    <= wrap;
    end
  end

  // NOTE: assigning a default before any branch keeps always_comb latch-free.
  always_comb begin
    state_d = state_q;
    if (clear_cmd) begin
      state_d = IDLE;
    end else if (load_cmd) begin
      state_d = RUN;
    end else if (inc_fire) begin
      state_d = (wrap && (ONESHOT != 0)) ? DONE : RUN;
    end
  end

  always_comb begin
    cout    = all_ones && count_cmd && (state_q == RUN);
    state_o = state_q;
  end

  assign load_ready = ready_q;
  assign tc         = tc_q;

endmodule

// File: tb/tb_cnt16_cascade.sv
// Directed bench for cnt16_cascade: a wrapping instance and a one-shot
// instance share stimulus; expected values are written out by hand.
module tb_cnt16_cascade;
  import cnt_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        cnt_en, cin, load_valid;
  logic [15:0] load_data;

  logic        rdy0, tc0, cout0, rdy1, tc1, cout1;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  st0, st1;

  int checks = 0;
  int errors = 0;
  int tc_hits0, tc_hits1;

  always #5 clk = ~clk;

  cnt16_cascade #(.WIDTH(16), .SLICE(4), .ONESHOT(0)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .cnt_en(cnt_en), .cin(cin),
    .load_valid(load_valid), .load_data(load_data), .load_ready(rdy0),
    .count(cnt0), .tc(tc0), .cout(cout0), .state_o(st0)
  );

  cnt16_cascade #(.WIDTH(16), .SLICE(4), .ONESHOT(1)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .cnt_en(cnt_en), .cin(cin),
    .load_valid(load_valid), .load_data(load_data), .load_ready(rdy1),
    .count(cnt1), .tc(tc1), .cout(cout1), .state_o(st1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic e, input logic c,
                       input logic v, input logic [15:0] d);
    mode = m; cnt_en = e; cin = c; load_valid = v; load_data = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(HOLD, 1'b0, 1'b0, 1'b0, 16'h0000);

    // reset for two cycles
    step(); step();
    check("rst_count", 32'(cnt0), 32'h0000);
    check("rst_tc", 32'(tc0), 32'h0);
    check("rst_state", 32'(st0), 32'(IDLE));
    check("rst_ready", 32'(rdy0), 32'h0);
    rst = 1'b0;
    step();
    check("ready_after_rst", 32'(rdy0), 32'h1);

    // 20 counts from zero
    drive(COUNT, 1'b1, 1'b1, 1'b0, 16'h0000);
    tc_hits0 = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tc0) tc_hits0++;
    end
    check("cnt20_count", 32'(cnt0), 32'h0014);
    check("cnt20_state", 32'(st0), 32'(RUN));
    check("cnt20_no_tc", 32'(tc_hits0), 32'd0);
    check("cnt20_os_count", 32'(cnt1), 32'h0014);

    // load FFFE then wrap
    drive(LOAD, 1'b0, 1'b0, 1'b1, 16'hFFFE);
    step();
    check("ld_fffe", 32'(cnt0), 32'hFFFE);
    check("ld_fffe_tc", 32'(tc0), 32'h0);
    drive(COUNT, 1'b1, 1'b1, 1'b0, 16'h0000);
    #1 check("cout_at_fffe", 32'(cout0), 32'h0);
    step();
    check("wrap_c1", 32'(cnt0), 32'hFFFF);
    check("wrap_c1_tc", 32'(tc0), 32'h0);
    check("cout_at_ffff", 32'(cout0), 32'h1);
    step();
    check("wrap_c2", 32'(cnt0), 32'h0000);
    check("wrap_c2_tc", 32'(tc0), 32'h1);
    check("cout_at_0000", 32'(cout0), 32'h0);
    check("wrap_state", 32'(st0), 32'(RUN));
    check("os_done_count", 32'(cnt1), 32'hFFFF);
    check("os_done_state", 32'(st1), 32'(DONE));
    check("os_done_tc", 32'(tc1), 32'h1);
    step();
    check("wrap_c3", 32'(cnt0), 32'h0001);
    check("wrap_c3_tc", 32'(tc0), 32'h0);
    check("os_done_tc_drop", 32'(tc1), 32'h0);

    // one-shot: load FFFF leaves DONE, no tc for a load to all-ones
    drive(LOAD, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    step();
    check("os_ld_count", 32'(cnt1), 32'hFFFF);
    check("os_ld_state", 32'(st1), 32'(RUN));
    check("os_ld_no_tc", 32'(tc1), 32'h0);
    drive(COUNT, 1'b1, 1'b1, 1'b0, 16'h0000);
    tc_hits1 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (tc1) tc_hits1++;
      check("os_hold_ffff", 32'(cnt1), 32'hFFFF);
    end
    check("os_state_done", 32'(st1), 32'(DONE));
    check("os_single_tc", 32'(tc_hits1), 32'd1);
    check("os_cout_done", 32'(cout1), 32'h0);
    drive(CLEAR, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    check("os_clr_count", 32'(cnt1), 32'h0000);
    check("os_clr_state", 32'(st1), 32'(IDLE));

    // slice carry 0 -> 1 with cin toggling
    drive(LOAD, 1'b0, 1'b0, 1'b1, 16'h000F);
    step();
    drive(COUNT, 1'b1, 1'b1, 1'b0, 16'h0000);
    step();
    check("carry_c1", 32'(cnt0), 32'h0010);
    cin = 1'b0;
    step();
    check("carry_cin0", 32'(cnt0), 32'h0010);
    cin = 1'b1;
    step();
    check("carry_c2", 32'(cnt0), 32'h0011);

    // clear beats count and load
    drive(LOAD, 1'b0, 1'b0, 1'b1, 16'h1234);
    step();
    check("ld_1234", 32'(cnt0), 32'h1234);
    drive(CLEAR, 1'b1, 1'b1, 1'b1, 16'hABCD);
    step();
    check("clr_count", 32'(cnt0), 32'h0000);
    check("clr_state", 32'(st0), 32'(IDLE));
    drive(LOAD, 1'b0, 1'b0, 1'b1, 16'hABCD);
    step();
    check("ld_abcd", 32'(cnt0), 32'hABCD);
    check("ld_abcd_state", 32'(st0), 32'(RUN));
    drive(LOAD, 1'b1, 1'b1, 1'b0, 16'h5555);
    step();
    check("ld_invalid_hold", 32'(cnt0), 32'hABCD);
    drive(HOLD, 1'b1, 1'b1, 1'b1, 16'h5555);
    step();
    check("hold_mode", 32'(cnt0), 32'hABCD);

    // reset at FFFF mid-count
    drive(LOAD, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    step();
    check("pre_rst_ffff", 32'(cnt0), 32'hFFFF);
    drive(COUNT, 1'b1, 1'b1, 1'b0, 16'h0000);
    rst = 1'b1;
    step();
    check("midrst_count", 32'(cnt0), 32'h0000);
    check("midrst_tc", 32'(tc0), 32'h0);
    check("midrst_state", 32'(st0), 32'(IDLE));
    check("midrst_ready", 32'(rdy0), 32'h0);
    rst = 1'b0;
    drive(HOLD, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    check("postrst_tc", 32'(tc0), 32'h0);
    check("postrst_ready", 32'(rdy0), 32'h1);
    check("postrst_count", 32'(cnt0), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
